// File: rtl/quad_pkg.sv
// Shared widths, saturation limits and types for the fixed-point sum-of-squares datapath.
package quad_pkg;
   localparam int WA = 14;
   localparam int WC = 29;
   localparam int WF = 8;
   localparam int WP = 2 * WA;

   localparam longint C_MAX = 64'sd268435455;
   localparam longint C_MIN = -64'sd268435456;

   typedef logic signed [WA-1:0] operand_t;
   typedef logic signed [WP-1:0] prod_t;
   typedef logic signed [WC-1:0] result_t;
endpackage

// File: rtl/fx_align_sat.sv
// Realigns a signed product by a signed shift (left for positive, truncating right for negative)
// and saturates it to the result width.
module fx_align_sat
   import quad_pkg::*;
(
   input  prod_t             i_val,
   input  logic signed [9:0] i_shift,
   output result_t           o_val
);

   localparam int XW       = 64;
   localparam int SHL_SAFE = XW - WP - 1;

   function automatic result_t sat_c(input logic signed [XW-1:0] v);
      logic signed [XW-1:0] w_lim;
      if (v > C_MAX) begin
         w_lim = C_MAX;
      end else if (v < C_MIN) begin
         w_lim = C_MIN;
      end else begin
         w_lim = v;
      end
      return w_lim[WC-1:0];
   endfunction

   logic signed [XW-1:0] w_ext;
   logic signed [XW-1:0] w_wide;
   logic        [9:0]    w_lsh;
   logic        [10:0]   w_rsh;

   always_comb begin
      w_ext  = {{(XW-WP){i_val[WP-1]}}, i_val};
      w_lsh  = i_shift;
      w_rsh  = -$signed({i_shift[9], i_shift});
      w_wide = '0;
      if (!i_shift[9]) begin
         // Large left shifts would overflow the intermediate; any nonzero value is already past the clamp.
         if (w_lsh > 10'(SHL_SAFE)) begin
            if (i_val == '0) begin
               w_wide = '0;
            end else if (i_val[WP-1]) begin
               w_wide = C_MIN;
            end else begin
               w_wide = C_MAX;
            end
         end else begin
            w_wide = w_ext <<< w_lsh;
         end
      end else begin
         if (w_rsh >= 11'(XW)) begin
            w_wide = '0;
         end else begin
            w_wide = w_ext >>> w_rsh;
         end
      end
   end

   assign o_val = sat_c(w_wide);

endmodule

// File: rtl/top.sv
// Three-stage pipelined c = a^2 + b^2 with runtime fractional formats, truncation and saturation.
// Format fields ride the pipeline with their operands so format changes apply per sample.
module top
   import quad_pkg::*;
(
   input  logic          clk,
   input  logic          rstn,
   input  logic [WF-1:0] num_frac_a,
   input  logic [WF-1:0] num_frac_b,
   input  logic [WF-1:0] num_frac_c,
   input  operand_t      a,
   input  operand_t      b,
   output result_t       c
);

   function automatic result_t sat_sum(input logic signed [WC:0] s);
      result_t w_res;
      if (longint'(s) > C_MAX) begin
         w_res = C_MAX[WC-1:0];
      end else if (longint'(s) < C_MIN) begin
         w_res = C_MIN[WC-1:0];
      end else begin
         w_res = s[WC-1:0];
      end
      return w_res;
   endfunction

   operand_t      r_a_p0, r_b_p0;
   logic [WF-1:0] r_fa_p0, r_fb_p0, r_fc_p0;
   prod_t         r_sa_p1, r_sb_p1;
   logic [WF-1:0] r_fa_p1, r_fb_p1, r_fc_p1;
   result_t       r_c_p2;

   logic signed [9:0]  w_da, w_db;
   result_t            w_ala, w_alb;
   logic signed [WC:0] w_sum;

   // Stage 0: capture operands and formats
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_a_p0  <= '0;
         r_b_p0  <= '0;
         r_fa_p0 <= '0;
         r_fb_p0 <= '0;
         r_fc_p0 <= '0;
      end else begin
         r_a_p0  <= a;
         r_b_p0  <= b;
         r_fa_p0 <= num_frac_a;
         r_fb_p0 <= num_frac_b;
         r_fc_p0 <= num_frac_c;
      end
   end

   // Stage 1: squares
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sa_p1 <= '0;
         r_sb_p1 <= '0;
         r_fa_p1 <= '0;
         r_fb_p1 <= '0;
         r_fc_p1 <= '0;
      end else begin
         r_sa_p1 <= prod_t'(r_a_p0) * prod_t'(r_a_p0);
         r_sb_p1 <= prod_t'(r_b_p0) * prod_t'(r_b_p0);
         r_fa_p1 <= r_fa_p0;
         r_fb_p1 <= r_fb_p0;
         r_fc_p1 <= r_fc_p0;
      end
   end

   // Stage 2: align both squares to c's format, add, saturate
   assign w_da = $signed({2'b00, r_fc_p1}) - $signed({1'b0, r_fa_p1, 1'b0});
   assign w_db = $signed({2'b00, r_fc_p1}) - $signed({1'b0, r_fb_p1, 1'b0});

   fx_align_sat u_align_a (
      .i_val   (r_sa_p1),
      .i_shift (w_da),
      .o_val   (w_ala)
   );

   fx_align_sat u_align_b (
      .i_val   (r_sb_p1),
      .i_shift (w_db),
      .o_val   (w_alb)
   );

   assign w_sum = {w_ala[WC-1], w_ala} + {w_alb[WC-1], w_alb};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_c_p2 <= '0;
      end else begin
         r_c_p2 <= sat_sum(w_sum);
      end
   end

   assign c = r_c_p2;

endmodule

// File: tb/tb_top.sv
// Directed and streaming bench for the sum-of-squares pipeline.
module tb_top;

   logic               clk;
   logic               rstn;
   logic [7:0]         num_frac_a, num_frac_b, num_frac_c;
   logic signed [13:0] a, b;
   logic signed [28:0] c;

   int n_chk;
   int n_err;

   top dut (
      .clk        (clk),
      .rstn       (rstn),
      .num_frac_a (num_frac_a),
      .num_frac_b (num_frac_b),
      .num_frac_c (num_frac_c),
      .a          (a),
      .b          (b),
      .c          (c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [28:0] obs, input logic signed [28:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input int va, input int vb, input int fa, input int fb, input int fc);
      a          = 14'(va);
      b          = 14'(vb);
      num_frac_a = 8'(fa);
      num_frac_b = 8'(fb);
      num_frac_c = 8'(fc);
   endtask

   task automatic run_vec(input string tag, input int va, input int vb, input int fa, input int fb,
                          input int fc, input logic signed [28:0] exp);
      drive(va, vb, fa, fb, fc);
      tick();
      tick();
      tick();
      chk(tag, c, exp);
   endtask

   // Reference: exact square, shift by (fc - 2*f), floor on right shift, then clamp the sum.
   function automatic logic signed [28:0] model(input int va, input int vb, input int fa, input int fb, input int fc);
      longint sa, sb, ta, tb, s;
      int da, db;
      sa = longint'(va) * longint'(va);
      sb = longint'(vb) * longint'(vb);
      da = fc - 2 * fa;
      db = fc - 2 * fb;
      ta = (da >= 0) ? (sa <<< da) : (sa >>> (-da));
      tb = (db >= 0) ? (sb <<< db) : (sb >>> (-db));
      s  = ta + tb;
      if (s > 64'sd268435455) s = 64'sd268435455;
      return s[28:0];
   endfunction

   logic signed [28:0] hist [0:999];

   initial begin
      int base;
      logic signed [13:0] ra, rb;
      int rfa, rfb, rfc;
      n_chk = 0;
      n_err = 0;
      rstn  = 1'b0;
      drive(100, 100, 0, 0, 0);

      for (int i = 0; i < 15; i++) begin
         tick();
         chk("reset_hold", c, 29'sd0);
      end
      rstn = 1'b1;
      tick();
      chk("post_rst_edge1", c, 29'sd0);
      tick();
      chk("post_rst_edge2", c, 29'sd0);
      tick();
      chk("post_rst_edge3", c, 29'sd20000);

      drive(3, 4, 0, 0, 0);
      tick();
      drive(-5, 12, 0, 0, 0);
      tick();
      tick();
      chk("int_3_4", c, 29'sd25);
      tick();
      chk("int_m5_12", c, 29'sd169);

      run_vec("ext_min_min", -8192, -8192, 0, 0, 0, 29'sd134217728);
      run_vec("ext_max_min", 8191, -8192, 0, 0, 0, 29'sd134201345);
      run_vec("frac_fc2", 3, 0, 1, 0, 2, 29'sd9);
      run_vec("frac_trunc", 3, 0, 1, 0, 0, 29'sd2);
      run_vec("frac_half", 4096, 4096, 13, 13, 2, 29'sd2);
      run_vec("sat_fc28", 8191, 8191, 0, 0, 28, 29'sd268435455);
      run_vec("oor_fa200", 1, 3, 200, 0, 0, 29'sd9);
      run_vec("oor_fc255", 1, 0, 0, 0, 255, 29'sd268435455);
      run_vec("oor_mixed", -8192, -8192, 60, 60, 100, 29'sd128);

      base = 0;
      for (int i = 0; i < 1000; i++) begin
         if (i == 500) begin
            rstn = 1'b0;
            #2;
            chk("async_rst", c, 29'sd0);
            tick();
            chk("async_rst_hold", c, 29'sd0);
            rstn = 1'b1;
            base = i;
         end
         ra  = 14'($urandom_range(0, 16383));
         rb  = 14'($urandom_range(0, 16383));
         rfa = $urandom_range(0, 13);
         rfb = $urandom_range(0, 13);
         rfc = $urandom_range(0, 28);
         drive(int'(ra), int'(rb), rfa, rfb, rfc);
         hist[i] = model(int'(ra), int'(rb), rfa, rfb, rfc);
         tick();
         if (i - base >= 2) chk("stream", c, hist[i-2]);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
